iobuf_wb_arbiter: RTL and testbench

IOBUF_WB_ARBITER -- requirements
Module: iobuf_wb_arbiter

---
 rtl/arb_rr_pick.sv | 31 +++
 rtl/iobuf_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_iobuf_wb_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/arb_rr_pick.sv
// Round-robin picker: chooses the first requester after `last`, wrapping modulo N.
// Purely combinational, so the caller decides when the choice is sampled.
module arb_rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt,
  output logic          valid
);

  logic [IW:0] cand;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, last} + (IW+1)'(k + 1);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        gnt   = cand[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iobuf_wb_arbiter.sv
// Wishbone arbiter for the I/O buffer: round-robin over N masters onto one slave,
// with a per-access wait timeout that completes the access with all-ones data.
module iobuf_wb_arbiter #(
  parameter  int unsigned N       = 3,
  parameter  int unsigned AW      = 14,
  parameter  int unsigned DW      = 32,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned MW      = DW / 8
) (
  input  logic            clk_sys,
  input  logic            rst_sys,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  input  logic [N*MW-1:0] m_wmsk,
  input  logic [N-1:0]    m_we,
  input  logic [N-1:0]    m_cyc,
  output logic [N-1:0]    m_ack,
  output logic [DW-1:0]   m_rdata,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [MW-1:0]   s_wmsk,
  output logic            s_we,
  output logic            s_cyc,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_rdata,
  output logic            err_stb,
  output logic [1:0]      err_mst
);

  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = 8;

  typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_t;

  state_t          state_q;
  logic [IW-1:0]   g_q, last_q;
  logic [CntW-1:0] cnt_q;

  logic [IW-1:0] pick_gnt;
  logic          pick_valid;
  logic          busy, at_limit, ack_ok, tmo;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [MW-1:0] sel_wmsk;
  logic          sel_we, sel_cyc;

  arb_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (m_cyc),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmsk  = '0;
    sel_we    = 1'b0;
    sel_cyc   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g_q == IW'(i)) begin
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*DW +: DW];
        sel_wmsk  = m_wmsk[i*MW +: MW];
        sel_we    = m_we[i];
        sel_cyc   = m_cyc[i];
      end
    end
  end

  // A real ack on the limit cycle takes priority over the timeout.
  always_comb begin
    busy     = (state_q == StBusy);
    at_limit = (cnt_q == CntW'(TIMEOUT));
    ack_ok   = busy && sel_cyc && s_ack;
    tmo      = busy && sel_cyc && !s_ack && at_limit;
    s_cyc    = busy && sel_cyc && !at_limit;
    s_addr   = busy ? sel_addr  : '0;
    s_wdata  = busy ? sel_wdata : '0;
    s_wmsk   = busy ? sel_wmsk  : '0;
    s_we     = busy && sel_we;
    m_ack    = '0;
    for (int i = 0; i < N; i++) begin
      m_ack[i] = (ack_ok || tmo) && (g_q == IW'(i));
    end
    m_rdata  = tmo ? '1 : (ack_ok ? s_rdata : '0);
    err_stb  = tmo;
    err_mst  = tmo ? 2'(g_q) : 2'b00;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q <= StIdle;
      g_q     <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            g_q     <= pick_gnt;
            last_q  <= pick_gnt;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          // Master withdrawal, ack or timeout all end the access.
          if (!sel_cyc || s_ack || at_limit) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iobuf_wb_arbiter.sv
// Randomized bench: masters and slave driven from the bench, each grant predicted
// from round-robin order, ack latency, timeout and withdrawal rules.
module tb_iobuf_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 4;

  logic            clk_sys = 1'b0;
  logic            rst_sys;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*MW-1:0] m_wmsk;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rdata;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [MW-1:0]   s_wmsk;
  logic            s_we;
  logic            s_cyc;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;
  logic            err_stb;
  logic [1:0]      err_mst;

  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];
  logic [MW-1:0] a_wmsk  [N];
  logic          a_we    [N];

  int n_checks = 0;
  int n_pass   = 0;
  int last_m   = N - 1;

  iobuf_wb_arbiter #(
    .N       (N),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wmsk  (m_wmsk),
    .m_we    (m_we),
    .m_cyc   (m_cyc),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wmsk  (s_wmsk),
    .s_we    (s_we),
    .s_cyc   (s_cyc),
    .s_ack   (s_ack),
    .s_rdata (s_rdata),
    .err_stb (err_stb),
    .err_mst (err_mst)
  );

  always #5 clk_sys = ~clk_sys;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wmsk  = '0;
    m_we    = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = a_addr[i];
      m_wdata[i*DW +: DW] = a_wdata[i];
      m_wmsk[i*MW +: MW]  = a_wmsk[i];
      m_we[i]             = a_we[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Next master in cyclic order after `last` that is requesting, or -1.
  function automatic int rr_next(input logic [N-1:0] req, input int last);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (last + i) % N;
      if (req[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    a_addr[i]  = AW'($urandom);
    a_wdata[i] = $urandom;
    a_wmsk[i]  = MW'($urandom);
    a_we[i]    = 1'($urandom);
    m_cyc[i]   = 1'b1;
  endtask

  task automatic refill(input int done);
    if (done >= 0) begin
      if ($urandom_range(0, 1) == 1) new_req(done);
      else m_cyc[done] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_cyc[i] && $urandom_range(0, 9) < 4) new_req(i);
    end
  endtask

  // Entered and left at a negedge with the arbiter idle.
  task automatic do_grant();
    int exp_g, lat, lim, abort_at;
    logic [DW-1:0] rd;
    s_ack = 1'b0;
    #1;
    check("idle_s_cyc", 64'(s_cyc), 64'd0);
    check("idle_m_ack", 64'(m_ack), 64'd0);
    exp_g = rr_next(m_cyc, last_m);
    if (exp_g < 0) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      refill(-1);
      return;
    end
    lat      = $urandom_range(0, TO + 2);
    lim      = (lat < TO) ? lat : TO;
    abort_at = -1;
    if (lim >= 1 && $urandom_range(0, 7) == 0) abort_at = $urandom_range(0, lim - 1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    for (int c = 0; c <= TO; c++) begin
      rd      = $urandom;
      s_rdata = rd;
      s_ack   = (c == lat);
      if (c == abort_at) m_cyc[exp_g] = 1'b0;
      #1;
      if (c == abort_at) begin
        check("abort_s_cyc", 64'(s_cyc), 64'd0);
        check("abort_m_ack", 64'(m_ack), 64'd0);
        break;
      end else if (c == lat) begin
        check("ack_m_ack", 64'(m_ack), 64'(1 << exp_g));
        check("ack_rdata", 64'(m_rdata), 64'(rd));
        check("ack_err", 64'(err_stb), 64'd0);
        if (c < TO) check("ack_s_cyc", 64'(s_cyc), 64'd1);
        break;
      end else if (c == TO) begin
        check("to_s_cyc", 64'(s_cyc), 64'd0);
        check("to_m_ack", 64'(m_ack), 64'(1 << exp_g));
        check("to_rdata", 64'(m_rdata), 64'hFFFF_FFFF);
        check("to_err_stb", 64'(err_stb), 64'd1);
        check("to_err_mst", 64'(err_mst), 64'(exp_g));
        break;
      end else begin
        check("busy_s_cyc", 64'(s_cyc), 64'd1);
        check("busy_addr", 64'(s_addr), 64'(a_addr[exp_g]));
        check("busy_wdata", 64'(s_wdata), 64'(a_wdata[exp_g]));
        check("busy_wmsk", 64'(s_wmsk), 64'(a_wmsk[exp_g]));
        check("busy_we", 64'(s_we), 64'(a_we[exp_g]));
        check("busy_m_ack", 64'(m_ack), 64'd0);
        check("busy_rdata", 64'(m_rdata), 64'd0);
        check("busy_err", 64'(err_stb), 64'd0);
      end
      @(posedge clk_sys);
      @(negedge clk_sys);
    end
    last_m = exp_g;
    @(posedge clk_sys);
    @(negedge clk_sys);
    s_ack = 1'b0;
    refill((abort_at < 0) ? exp_g : -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_sys = 1'b1;
    m_cyc   = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = '0;
      a_wdata[i] = '0;
      a_wmsk[i]  = '0;
      a_we[i]    = 1'b0;
    end
    repeat (2) @(negedge clk_sys);
    #1;
    check("rst_s_cyc", 64'(s_cyc), 64'd0);
    check("rst_m_ack", 64'(m_ack), 64'd0);
    check("rst_err_stb", 64'(err_stb), 64'd0);
    check("rst_err_mst", 64'(err_mst), 64'd0);
    check("rst_rdata", 64'(m_rdata), 64'd0);
    rst_sys = 1'b0;

    // Master 1 alone is granted, then reset lands mid-access.
    new_req(1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
    check("m1_s_cyc", 64'(s_cyc), 64'd1);
    check("m1_addr", 64'(s_addr), 64'(a_addr[1]));
    s_ack   = 1'b1;
    rst_sys = 1'b1;
    #1;
    check("midrst_s_cyc", 64'(s_cyc), 64'd0);
    check("midrst_m_ack", 64'(m_ack), 64'd0);
    @(negedge clk_sys);
    rst_sys = 1'b0;
    s_ack   = 1'b0;
    m_cyc   = '0;
    new_req(0);
    new_req(1);
    last_m = N - 1;

    repeat (300) do_grant();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
